// File: rtl/ext_pkg.sv
// Shared encodings for the immediate/data extender.
package ext_pkg;

  typedef logic [2:0] ext_op_t;

  localparam ext_op_t EXT_SIGN  = 3'b000;
  localparam ext_op_t EXT_UPPER = 3'b001;
  localparam ext_op_t EXT_ZERO  = 3'b010;
  localparam ext_op_t EXT_BROFF = 3'b011;
  localparam ext_op_t EXT_BSIGN = 3'b100;
  localparam ext_op_t EXT_BZERO = 3'b101;

endpackage

// File: rtl/ext_core.sv
// Combinational extension of an IN_W immediate to OUT_W bits.
// Unused encodings (110, 111) yield zero and are not treated as errors.
module ext_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       ext_op,
  output logic [OUT_W-1:0] data
);
  import ext_pkg::*;

  logic [OUT_W-1:0] sext;

  // Select the extended form of imm according to ext_op.
  always_comb begin
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    data = '0;
    case (ext_op_t'(ext_op))
      EXT_SIGN:  data = sext;
      EXT_UPPER: data = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_ZERO:  data = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_BROFF: data = sext << 2;
      EXT_BSIGN: data = {{(OUT_W-8){imm[7]}}, imm[7:0]};
      EXT_BZERO: data = {{(OUT_W-8){1'b0}}, imm[7:0]};
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Elastic pipelined extender: ext_core feeds DEPTH valid/data/tag stages.
//
// Handshake: a transfer on either side happens on the rising edge where
// valid && ready. Stage k advances when it is empty or stage k+1 advances;
// the last stage advances on out_ready. in_ready never looks at in_valid,
// and while a result is stalled (out_valid && !out_ready) it holds still.
// flush drops every in-flight item and the item offered on that edge.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  import ext_pkg::*;

  logic [OUT_W-1:0] ext_data;
  logic [DEPTH-1:0] valid_w;
  logic [DEPTH-1:0] adv;
  logic [OUT_W-1:0] data_w [DEPTH];
  logic [TAG_W-1:0] tag_w  [DEPTH];

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm    (imm),
    .ext_op (ext_op),
    .data   (ext_data)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_valid;
    logic [OUT_W-1:0] src_data;
    logic [TAG_W-1:0] src_tag;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = ext_data;
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_valid = valid_w[k-1];
      assign src_data  = data_w[k-1];
      assign src_tag   = tag_w[k-1];
    end

    if (k == DEPTH-1) begin : g_last
      assign adv[k] = !valid_q || out_ready;
    end else begin : g_mid
      assign adv[k] = !valid_q || adv[k+1];
    end

    assign valid_w[k] = valid_q;
    assign data_w[k]  = data_q;
    assign tag_w[k]   = tag_q;

    // Stage register: take the upstream item when advancing; payload only
    // loads on a real item so an emptied stage keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (adv[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          data_q <= src_data;
          tag_q  <= src_tag;
        end
      end
    end
  end

  // During flush the offered input is swallowed, so ready is reported high.
  assign in_ready  = flush || adv[0];
  assign out_valid = valid_w[DEPTH-1];
  assign out_data  = data_w[DEPTH-1];
  assign out_tag   = tag_w[DEPTH-1];

endmodule
